// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) after the data bits.
module uart_tx_frame #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic                 stop_reg, stop_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_reg, tx_next;
    logic                 bit_tick;

`ifdef UART_TX_PARITY_EN
    logic                 parity_reg, parity_next;
`else
    logic                 unused_parity_cfg;
    assign unused_parity_cfg = 1'(PARITY_ODD);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            div_reg    <= '0;
            bit_reg    <= '0;
            stop_reg   <= 1'b0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            stop_reg   <= stop_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign bit_tick = (div_reg == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_next  = state_reg;
        div_next    = bit_tick ? '0 : div_reg + DIV_W'(1);
        bit_next    = bit_reg;
        stop_next   = stop_reg;
        shift_next  = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                div_next = '0;
                if (valid) begin
                    state_next  = ST_START;
                    shift_next  = data;
                    bit_next    = '0;
                    stop_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            ST_START: begin
                if (bit_tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_reg == 1'(STOP_BITS - 1)) state_next = ST_IDLE;
                    else                               stop_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // tx is computed from the next state so the line register changes on the same edge as the FSM
    always_comb begin
        ready   = (state_reg == ST_IDLE);
        busy    = (state_reg != ST_IDLE);
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_reg;
`endif
            default:   tx_next = 1'b1;
        endcase
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: a default 8N1 instance (a) and a fast
// 7-data/2-stop/odd-parity instance (b), checked slot by slot against hand-built frames.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       poke;
    logic [8:0] data_s;
    logic       valid_s;

    logic [7:0] data_a;
    logic       valid_a, ready_a, tx_a, busy_a;
    logic [6:0] data_b;
    logic       valid_b, ready_b, tx_b, busy_b;
    logic       tx_s, ready_s, busy_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign data_a  = data_s[7:0];
    assign data_b  = data_s[6:0];
    assign valid_a = valid_s & ~sel;
    assign valid_b = valid_s & sel;
    assign tx_s    = sel ? tx_b    : tx_a;
    assign ready_s = sel ? ready_b : ready_a;
    assign busy_s  = sel ? busy_b  : busy_a;

    uart_tx_frame #(.CLK_DIV(868), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .data(data_a), .valid(valid_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a)
    );

    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .data(data_b), .valid(valid_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Called at a negedge with the selected instance idle; returns at the negedge of its first IDLE cycle.
    task automatic send(input logic [8:0] d, input bit keep);
        int   nb, ns, cdiv, odd, nslots, txok, bzok, rdok;
        logic exp_bit, par;
        logic [8:0] mask;
        nb     = sel ? 7 : 8;
        ns     = sel ? 2 : 1;
        cdiv   = sel ? 4 : 868;
        odd    = sel ? 1 : 0;
        nslots = 1 + nb + P + ns;
        mask   = 9'((1 << nb) - 1);
        par    = (^(d & mask)) ^ odd[0];
        data_s  = d;
        valid_s = 1'b1;
        check($sformatf("%s_%02h_ready_before", sel ? "b" : "a", d), ready_s, 1);
        @(posedge clk);
        #1;
        if (!keep) valid_s = 1'b0;
        data_s = ~d;
        for (int s = 0; s < nslots; s++) begin
            if (s == 0)                    exp_bit = 1'b0;
            else if (s <= nb)              exp_bit = d[s-1];
            else if (P == 1 && s == nb+1)  exp_bit = par;
            else                           exp_bit = 1'b1;
            txok = 0; bzok = 0; rdok = 0;
            for (int k = 0; k < cdiv; k++) begin
                @(negedge clk);
                if (tx_s === exp_bit) txok++;
                if (busy_s === 1'b1)  bzok++;
                if (ready_s === 1'b0) rdok++;
                if (poke && s == 3 && k == 0) begin
                    valid_s = 1'b1;
                    data_s  = 9'h1FF;
                end else if (poke && s == 3 && k == 1) begin
                    valid_s = 1'b0;
                end
            end
            check($sformatf("%s_%02h_slot%0d_tx%0d", sel ? "b" : "a", d, s, exp_bit), txok, cdiv);
            check($sformatf("%s_%02h_slot%0d_busy", sel ? "b" : "a", d, s), bzok, cdiv);
            check($sformatf("%s_%02h_slot%0d_notready", sel ? "b" : "a", d, s), rdok, cdiv);
        end
        @(negedge clk);
        check($sformatf("%s_%02h_idle_tx", sel ? "b" : "a", d), tx_s, 1);
        check($sformatf("%s_%02h_idle_ready", sel ? "b" : "a", d), ready_s, 1);
        check($sformatf("%s_%02h_idle_busy", sel ? "b" : "a", d), busy_s, 0);
    endtask

    initial begin
        int idle_ok;
        rst_n   = 1'b0;
        sel     = 1'b0;
        poke    = 1'b0;
        valid_s = 1'b0;
        data_s  = '0;
        repeat (3) @(negedge clk);
        check("rst_a_tx", tx_a, 1);
        check("rst_a_ready", ready_a, 1);
        check("rst_a_busy", busy_a, 0);
        check("rst_b_tx", tx_b, 1);
        check("rst_b_ready", ready_b, 1);
        check("rst_b_busy", busy_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // default divider, 0x42 and an even-parity pattern
        send(9'h042, 1'b0);
        send(9'h003, 1'b0);

        // fast instance: back-to-back with valid held, then all-ones, then odd-parity patterns
        sel = 1'b1;
        @(negedge clk);
        send(9'h055, 1'b1);
        send(9'h02A, 1'b0);
        send(9'h07F, 1'b0);
        send(9'h001, 1'b0);
        send(9'h000, 1'b0);

        // reset in the middle of data bit 3
        data_s  = 9'h05A;
        valid_s = 1'b1;
        @(posedge clk);
        #1;
        valid_s = 1'b0;
        repeat (18) @(negedge clk);
        check("abort_mid_bit3", tx_s, 1'b1);
        check("abort_busy_before", busy_s, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_tx", tx_s, 1);
        check("abort_ready", ready_s, 1);
        check("abort_busy", busy_s, 0);
        send(9'h033, 1'b0);

        // new data pulsed while busy must not disturb the frame or start another
        poke = 1'b1;
        send(9'h04C, 1'b0);
        poke = 1'b0;
        idle_ok = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy_s === 1'b0 && tx_s === 1'b1) idle_ok++;
        end
        check("poke_no_second_frame", idle_ok, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
